wb_regfile_writer: RTL and testbench
====================================

WB_REGFILE_WRITER -- requirements
Module: wb_regfile_writer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: alu_valid in 1, alu_ready out 1, alu_rd in 5, alu_data in 32: ALU result source.
REQ-004 SHALL have ports: mem_valid in 1, mem_ready out 1, mem_rd in 5, mem_data in 32: raw load word source.
REQ-005 SHALL have ports: mem_funct3 in 3 (load type), mem_byte_off in 2 (address bits [1:0]).
REQ-006 SHALL have ports: write_enable out 1, w_addr out 5, w_data out 32: registered drive of the register file write port.
REQ-007 SHALL have port: pending_mask out 32; bit k set means a write to register k is in flight.

Function
REQ-008 SHALL hold one single-entry buffer per source (ALU buffer, MEM buffer), each holding rd, data and full flag.
REQ-009 SHALL capture a source on a rising edge where valid && ready; MEM data is formatted before capture.
REQ-010 SHALL drive src_ready = !full || (full && granted this cycle), giving one transfer per cycle per source when uncontended.
REQ-011 SHALL grant at most one full buffer per cycle; the granted buffer is cleared and the output register loaded on the next edge.
REQ-012 SHALL, when both buffers are full, grant the older entry (age bit); on equal age (captured on the same edge), grant MEM.
REQ-013 SHALL provide latency: capture at edge E, write_enable high for exactly the cycle after edge E+1 when uncontended.
REQ-014 SHALL, for a granted entry with rd==0, still consume the entry but keep write_enable low for that cycle.
REQ-015 SHALL format loads: LB/LH sign-extend, LBU/LHU zero-extend the byte/halfword selected by mem_byte_off; LW passes the word.
REQ-016 SHALL use bit 1 of mem_byte_off for halfword select, ignoring bit 0; any undefined funct3 is treated as LW.
REQ-017 SHALL set pending_mask as the OR of one-hot rd for each full buffer and for the output register while write_enable=1; bit 0 is always 0.
REQ-018 SHALL, on a capture and a grant of the same buffer on one edge, hold the new entry (full stays 1).
REQ-019 SHALL, when both buffers hold the same rd, write the older entry first, so the younger value is the last written.

Reset
REQ-020 SHALL, while reset=1, clear both buffers, the age bit, write_enable, w_addr and w_data to 0, independent of clk.
REQ-021 SHALL force alu_ready=0, mem_ready=0 and pending_mask=0 while reset=1.
REQ-022 SHALL discard any buffered entry when reset is asserted mid-operation; no write is issued after reset deasserts.

Structure
REQ-023 SHALL take load funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101) and XLEN=32 / register address width 5 from the shared core package.
REQ-024 SHALL place load byte/halfword extraction in a combinational sub-module load_formatter.

Verification
REQ-025 SHALL cover: ALU capture rd=5, data=0xDEADBEEF -> write_enable=1, w_addr=5, w_data=0xDEADBEEF two edges later, single cycle.
REQ-026 SHALL cover: MEM LB, word 0x12345680, off=0 -> w_data=0xFFFFFF80; LBU same -> 0x00000080; LH off=2 -> 0x00001234.
REQ-027 SHALL cover: ALU rd=3 and MEM rd=3 captured on the same edge -> MEM written first, ALU on the next cycle; alu_ready=0 for one cycle.
REQ-028 SHALL cover: ALU capture rd=0, data=0xFFFF -> entry consumed, write_enable stays 0, alu_ready returns to 1.
REQ-029 SHALL cover: ALU streams rd=1..8 on 8 consecutive cycles -> 8 consecutive writes, alu_ready held 1, pending_mask tracks in-flight rds.
REQ-030 SHALL cover: reset asserted between edges with both buffers full -> all outputs 0 immediately; no write after deassertion.

Source files
------------

// File: rtl/wb_regfile_writer_pkg.sv
// Shared core definitions for the register-file writeback path.
// Covers load funct3 encodings, datapath widths, the buffer entry type and the rd one-hot helper.
package wb_regfile_writer_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } load_funct3_e;

  typedef struct packed {
    logic              full;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // x0 is never tracked as pending, so bit 0 of the result is always clear
  function automatic logic [XLEN-1:0] rdOneHot(input logic [REG_AW-1:0] rd);
    logic [XLEN-1:0] mask;
    mask = '0;
    mask[rd] = 1'b1;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/wb_regfile_writer_if.sv
// Bundle of the ALU/MEM source handshakes and the register-file write port.
// The master side drives the sources; the slave side is the writeback block.
interface wb_regfile_writer_if;
  import wb_regfile_writer_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic [2:0]        mem_funct3;
  logic [1:0]        mem_byte_off;

  logic              write_enable;
  logic [REG_AW-1:0] w_addr;
  logic [XLEN-1:0]   w_data;
  logic [XLEN-1:0]   pending_mask;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data, mem_funct3, mem_byte_off,
    input  alu_ready, mem_ready, write_enable, w_addr, w_data, pending_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data, mem_funct3, mem_byte_off,
    output alu_ready, mem_ready, write_enable, w_addr, w_data, pending_mask
  );
endinterface

// File: rtl/wb_regfile_writer_load_formatter.sv
// Combinational load alignment: extracts the byte or halfword addressed by the low address bits
// and sign- or zero-extends it. Unrecognised funct3 values pass the raw word through.
module load_formatter
  import wb_regfile_writer_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_byteOff,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfwords are assumed aligned, so only the upper offset bit selects the half
  always_comb begin
    w_byte = i_word[7:0];
    case (i_byteOff)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_byteOff[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      LOAD_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      LOAD_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
      LOAD_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      LOAD_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
      default:  o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_regfile_writer.sv
// Writeback arbiter: one single-entry buffer per source (ALU, MEM) feeding a registered
// register-file write port. Oldest entry wins; on a tie MEM goes first.
module wb_regfile_writer
  import wb_regfile_writer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  wb_regfile_writer_if.slave bus
);

  wb_entry_t         r_alu;
  wb_entry_t         r_mem;
  logic              r_aluOlder;
  logic              r_writeEnable;
  logic [REG_AW-1:0] r_wAddr;
  logic [XLEN-1:0]   r_wData;

  logic              w_grantAlu;
  logic              w_grantMem;
  logic              w_aluReady;
  logic              w_memReady;
  logic              w_aluCap;
  logic              w_memCap;
  logic [XLEN-1:0]   w_memFmt;

  load_formatter u_loadFormatter (
    .i_word    (bus.mem_data),
    .i_funct3  (bus.mem_funct3),
    .i_byteOff (bus.mem_byte_off),
    .o_data    (w_memFmt)
  );

  // r_aluOlder is only meaningful while both buffers are full; clear means MEM wins
  assign w_grantAlu = r_alu.full && (!r_mem.full || r_aluOlder);
  assign w_grantMem = r_mem.full && (!r_alu.full || !r_aluOlder);

  assign w_aluReady = !reset && (!r_alu.full || w_grantAlu);
  assign w_memReady = !reset && (!r_mem.full || w_grantMem);
  assign w_aluCap   = bus.alu_valid && w_aluReady;
  assign w_memCap   = bus.mem_valid && w_memReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu      <= '0;
      r_mem      <= '0;
      r_aluOlder <= 1'b0;
    end else begin
      if (w_aluCap) begin
        r_alu <= '{full: 1'b1, rd: bus.alu_rd, data: bus.alu_data};
      end else if (w_grantAlu) begin
        r_alu.full <= 1'b0;
      end

      if (w_memCap) begin
        r_mem <= '{full: 1'b1, rd: bus.mem_rd, data: w_memFmt};
      end else if (w_grantMem) begin
        r_mem.full <= 1'b0;
      end

      // A fresh ALU capture is never older; a lone MEM capture makes any held ALU entry older
      if (w_aluCap) begin
        r_aluOlder <= 1'b0;
      end else if (w_memCap) begin
        r_aluOlder <= 1'b1;
      end
    end
  end

  // A granted x0 entry is drained without raising write_enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_writeEnable <= 1'b0;
      r_wAddr       <= '0;
      r_wData       <= '0;
    end else if (w_grantMem) begin
      r_writeEnable <= (r_mem.rd != '0);
      r_wAddr       <= r_mem.rd;
      r_wData       <= r_mem.data;
    end else if (w_grantAlu) begin
      r_writeEnable <= (r_alu.rd != '0);
      r_wAddr       <= r_alu.rd;
      r_wData       <= r_alu.data;
    end else begin
      r_writeEnable <= 1'b0;
    end
  end

  assign bus.alu_ready    = w_aluReady;
  assign bus.mem_ready    = w_memReady;
  assign bus.write_enable = r_writeEnable;
  assign bus.w_addr       = r_wAddr;
  assign bus.w_data       = r_wData;
  assign bus.pending_mask = reset ? '0 :
                            ((r_alu.full    ? rdOneHot(r_alu.rd) : '0) |
                             (r_mem.full    ? rdOneHot(r_mem.rd) : '0) |
                             (r_writeEnable ? rdOneHot(r_wAddr)  : '0));

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Directed self-checking bench for wb_regfile_writer.
// Covers reset state, the ALU and MEM paths, arbitration, x0 drop, streaming and reset abort.
module tb_wb_regfile_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectorCount = 0;
  int   miscompareCount = 0;

  wb_regfile_writer_if bus();

  wb_regfile_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] oneHot(input int r);
    return (r <= 0 || r > 31) ? 32'h0 : (32'h1 << r);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic aluV, input logic [4:0] aluRd, input logic [31:0] aluData,
                               input logic memV, input logic [4:0] memRd, input logic [31:0] memData,
                               input logic [2:0] f3, input logic [1:0] off);
    bus.alu_valid    = aluV;
    bus.alu_rd       = aluRd;
    bus.alu_data     = aluData;
    bus.mem_valid    = memV;
    bus.mem_rd       = memRd;
    bus.mem_data     = memData;
    bus.mem_funct3   = f3;
    bus.mem_byte_off = off;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadCase(input string tag, input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] word, input logic [31:0] expected);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, word, f3, off);
    tick();
    idle();
    tick();
    checkOutput({tag, "_we"}, {31'h0, bus.write_enable}, 32'h1);
    checkOutput({tag, "_data"}, bus.w_data, expected);
    tick();
  endtask

  initial begin
    idle();
    #3;
    checkOutput("rst_we", {31'h0, bus.write_enable}, 32'h0);
    checkOutput("rst_waddr", {27'h0, bus.w_addr}, 32'h0);
    checkOutput("rst_wdata", bus.w_data, 32'h0);
    checkOutput("rst_alu_ready", {31'h0, bus.alu_ready}, 32'h0);
    checkOutput("rst_mem_ready", {31'h0, bus.mem_ready}, 32'h0);
    checkOutput("rst_pending", bus.pending_mask, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("post_rst_alu_ready", {31'h0, bus.alu_ready}, 32'h1);
    checkOutput("post_rst_mem_ready", {31'h0, bus.mem_ready}, 32'h1);

    // Single ALU write, two edges of latency, one cycle wide
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
    tick();
    idle();
    checkOutput("alu_we_early", {31'h0, bus.write_enable}, 32'h0);
    checkOutput("alu_pend_buf", bus.pending_mask, 32'h0000_0020);
    tick();
    checkOutput("alu_we", {31'h0, bus.write_enable}, 32'h1);
    checkOutput("alu_waddr", {27'h0, bus.w_addr}, 32'd5);
    checkOutput("alu_wdata", bus.w_data, 32'hDEADBEEF);
    checkOutput("alu_pend_out", bus.pending_mask, 32'h0000_0020);
    tick();
    checkOutput("alu_we_after", {31'h0, bus.write_enable}, 32'h0);
    checkOutput("alu_pend_after", bus.pending_mask, 32'h0);

    loadCase("lb_off0",    3'b000, 2'd0, 32'h12345680, 32'hFFFFFF80);
    loadCase("lbu_off0",   3'b100, 2'd0, 32'h12345680, 32'h00000080);
    loadCase("lh_off2",    3'b001, 2'd2, 32'h12345680, 32'h00001234);
    loadCase("lh_off3",    3'b001, 2'd3, 32'h12345680, 32'h00001234);
    loadCase("lb_off1",    3'b000, 2'd1, 32'h12345680, 32'h00000056);
    loadCase("lbu_off3",   3'b100, 2'd3, 32'h12345680, 32'h00000012);
    loadCase("lb_off2",    3'b000, 2'd2, 32'hCAFE8001, 32'hFFFFFFFE);
    loadCase("lh_off0",    3'b001, 2'd0, 32'hCAFE8001, 32'hFFFF8001);
    loadCase("lhu_off0",   3'b101, 2'd0, 32'hCAFE8001, 32'h00008001);
    loadCase("lh_off2n",   3'b001, 2'd2, 32'hCAFE8001, 32'hFFFFCAFE);
    loadCase("lhu_off2",   3'b101, 2'd2, 32'hCAFE8001, 32'h0000CAFE);
    loadCase("lw_off1",    3'b010, 2'd1, 32'hCAFE8001, 32'hCAFE8001);
    loadCase("f3_011",     3'b011, 2'd0, 32'hCAFE8001, 32'hCAFE8001);
    loadCase("f3_111",     3'b111, 2'd2, 32'h12345680, 32'h12345680);

    // Same rd from both sources on one edge: MEM first, ALU stalls for one cycle
    applyStimulus(1'b1, 5'd3, 32'hAAAA0001, 1'b1, 5'd3, 32'hBBBB0002, 3'b010, 2'd0);
    tick();
    idle();
    checkOutput("tie_alu_ready", {31'h0, bus.alu_ready}, 32'h0);
    checkOutput("tie_mem_ready", {31'h0, bus.mem_ready}, 32'h1);
    checkOutput("tie_pend", bus.pending_mask, 32'h0000_0008);
    tick();
    checkOutput("tie_first_we", {31'h0, bus.write_enable}, 32'h1);
    checkOutput("tie_first_data", bus.w_data, 32'hBBBB0002);
    checkOutput("tie_alu_ready2", {31'h0, bus.alu_ready}, 32'h1);
    tick();
    checkOutput("tie_second_we", {31'h0, bus.write_enable}, 32'h1);
    checkOutput("tie_second_addr", {27'h0, bus.w_addr}, 32'd3);
    checkOutput("tie_second_data", bus.w_data, 32'hAAAA0001);
    tick();
    checkOutput("tie_done_we", {31'h0, bus.write_enable}, 32'h0);

    // x0 entry drains silently
    applyStimulus(1'b1, 5'd0, 32'h0000FFFF, 1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
    tick();
    idle();
    checkOutput("x0_alu_ready", {31'h0, bus.alu_ready}, 32'h1);
    checkOutput("x0_pend", bus.pending_mask, 32'h0);
    tick();
    checkOutput("x0_we", {31'h0, bus.write_enable}, 32'h0);
    checkOutput("x0_pend2", bus.pending_mask, 32'h0);
    tick();
    checkOutput("x0_we2", {31'h0, bus.write_enable}, 32'h0);

    // Back-to-back ALU stream rd=1..8
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        applyStimulus(1'b1, 5'(c + 1), 32'h11111111 * (c + 1), 1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
        checkOutput($sformatf("stream_ready_%0d", c), {31'h0, bus.alu_ready}, 32'h1);
      end else begin
        idle();
      end
      tick();
      begin
        int k;
        k = c + 1;
        checkOutput($sformatf("stream_we_%0d", k), {31'h0, bus.write_enable},
                    (k >= 2 && k <= 9) ? 32'h1 : 32'h0);
        if (k >= 2 && k <= 9) begin
          checkOutput($sformatf("stream_addr_%0d", k), {27'h0, bus.w_addr}, 32'(k - 1));
          checkOutput($sformatf("stream_data_%0d", k), bus.w_data, 32'h11111111 * (k - 1));
        end
        checkOutput($sformatf("stream_pend_%0d", k), bus.pending_mask,
                    ((k <= 8) ? oneHot(k) : 32'h0) | ((k >= 2 && k <= 9) ? oneHot(k - 1) : 32'h0));
      end
    end

    // Reset in the middle of a cycle with both buffers and the output register busy
    applyStimulus(1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
    tick();
    applyStimulus(1'b1, 5'd11, 32'hBBBBBBBB, 1'b1, 5'd9, 32'h99999999, 3'b010, 2'd0);
    tick();
    idle();
    checkOutput("busy_we", {31'h0, bus.write_enable}, 32'h1);
    checkOutput("busy_pend", bus.pending_mask, oneHot(7) | oneHot(9) | oneHot(11));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_we", {31'h0, bus.write_enable}, 32'h0);
    checkOutput("midrst_waddr", {27'h0, bus.w_addr}, 32'h0);
    checkOutput("midrst_wdata", bus.w_data, 32'h0);
    checkOutput("midrst_alu_ready", {31'h0, bus.alu_ready}, 32'h0);
    checkOutput("midrst_mem_ready", {31'h0, bus.mem_ready}, 32'h0);
    checkOutput("midrst_pend", bus.pending_mask, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rel_alu_ready", {31'h0, bus.alu_ready}, 32'h1);
    checkOutput("rel_mem_ready", {31'h0, bus.mem_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rel_we_%0d", i), {31'h0, bus.write_enable}, 32'h0);
      checkOutput($sformatf("rel_pend_%0d", i), bus.pending_mask, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
